// File: rtl/fpu_issue_controller_pkg.sv
// Shared encodings for the FPU issue controller: FPU operation codes,
// controller state encodings and the default watchdog limit.
package fpu_issue_controller_pkg;

    // FPU operation codes (same values as the FPU's own decoder)
    localparam logic [1:0] FPU_ADD  = 2'b00;
    localparam logic [1:0] FPU_SUB  = 2'b01;
    localparam logic [1:0] FPU_MUL  = 2'b10;
    localparam logic [1:0] FPU_SQRT = 2'b11;

    // Controller state encodings
    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] ISSUE = 2'b01;
    localparam logic [1:0] RESP  = 2'b10;

    // Default watchdog limit in ISSUE cycles
    localparam int unsigned DEFAULT_TIMEOUT = 64;

endpackage

// File: rtl/fpu_issue_controller.sv
// Upstream sequencer for the fixed-point FPU. Accepts one request, holds the
// operation and operands on the FPU until it reports ready (or the watchdog
// expires), then presents the result with its tag downstream. Outside ISSUE
// the FPU sees FPU_ADD, which restarts its multi-stage MUL/SQRT machines.
module fpu_issue_controller
    import fpu_issue_controller_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic [1:0]       fpu_operation,
    output logic [WIDTH-1:0] fpu_operand_1,
    output logic [WIDTH-1:0] fpu_operand_2,
    input  logic [WIDTH-1:0] fpu_result,
    input  logic             fpu_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_error,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]       r_state;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [TAG_W-1:0] r_tag;
    logic [WIDTH-1:0] r_result;
    logic             r_error;
    logic [CNT_W-1:0] r_cnt;

    logic w_idle;
    logic w_issue;
    logic w_resp;

    // State decode
    always_comb begin
        w_idle  = (r_state == IDLE);
        w_issue = (r_state == ISSUE);
        w_resp  = (r_state == RESP);
    end

    // Sequencer: capture request, wait for FPU or watchdog, hold response
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_op     <= FPU_ADD;
            r_a      <= '0;
            r_b      <= '0;
            r_tag    <= '0;
            r_result <= '0;
            r_error  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_op    <= in_op;
                        r_a     <= in_a;
                        r_b     <= in_b;
                        r_tag   <= in_tag;
                        r_cnt   <= '0;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    // fpu_ready takes priority over an expiring watchdog
                    if (fpu_ready) begin
                        r_result <= fpu_result;
                        r_error  <= 1'b0;
                        r_state  <= RESP;
                    end else if (r_cnt == CNT_LAST) begin
                        r_result <= '0;
                        r_error  <= 1'b1;
                        r_state  <= RESP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Handshake and FPU drive outputs
    always_comb begin
        in_ready      = w_idle;
        busy          = w_issue | w_resp;
        out_valid     = w_resp;
        out_result    = r_result;
        out_tag       = r_tag;
        out_error     = r_error;
        fpu_operation = w_issue ? r_op : FPU_ADD;
        fpu_operand_1 = r_a;
        fpu_operand_2 = r_b;
    end

endmodule

// File: doc/fpu_issue_controller.md
Name: fpu_issue_controller

Overview:
- Upstream sequencer for the fixed-point arithmetic unit (WIDTH/FBITS fixed-point ADD/SUB/MUL/SQRT).
- Accepts one operation request on a valid/ready handshake and drives the FPU operation code and operands, holding them stable until the FPU raises ready.
- Captures the FPU result and presents it downstream on a second valid/ready handshake.
- Guarantees a clean FPU restart between operations, guards against a hung FPU with a watchdog, and carries a tag end to end.

Parameters:
- WIDTH, 32, operand/result width; must match the FPU.
- TAG_W, 4, width of the request tag passed through to the response.
- TIMEOUT, 64, maximum ISSUE cycles before abort; legal range 2..65535.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- in_valid  in  1  request valid.
- in_ready  out  1  controller can accept a request.
- in_op  in  2  operation code, FPU encoding (FPU_ADD/FPU_SUB/FPU_MUL/FPU_SQRT from the shared defines).
- in_a  in  WIDTH  operand 1.
- in_b  in  WIDTH  operand 2 (ignored for SQRT, forwarded as given).
- in_tag  in  TAG_W  request tag.
- fpu_operation  out  2  to FPU operation.
- fpu_operand_1  out  WIDTH  to FPU operand_1.
- fpu_operand_2  out  WIDTH  to FPU operand_2.
- fpu_result  in  WIDTH  from FPU result.
- fpu_ready  in  1  from FPU ready (combinational on the FPU side).
- out_valid  out  1  response valid.
- out_ready  in  1  downstream accepts response.
- out_result  out  WIDTH  captured result.
- out_tag  out  TAG_W  tag of the request.
- out_error  out  1  1 = watchdog abort; out_result forced to 0.
- busy  out  1  high in ISSUE or RESP.

Behaviour:
- States: IDLE, ISSUE, RESP (2-bit encoding, registered).
- Reset (asynchronous, while reset = 0):
  - State goes to IDLE.
  - Operand, tag, result and counter registers clear to 0.
  - Outputs: out_valid=0, out_error=0, out_result=0, out_tag=0, in_ready=1, busy=0.
  - fpu_operation=FPU_ADD, fpu_operands=0.
  - Reset arriving mid-ISSUE or mid-RESP drops the operation silently; no response is produced.
- fpu_operation is FPU_ADD in every state except ISSUE. This resets the FPU multiply/sqrt stage machines and clears root_ready, so every issue starts from FPU stage 0.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at an edge: register in_op/in_a/in_b/in_tag, clear the watchdog counter, go to ISSUE.
- ISSUE:
  - fpu_operation = the registered op; fpu_operand_1/2 = the registered operands, stable for the whole state.
  - in_ready=0.
  - fpu_ready is sampled at each edge. If it is 1: out_result<=fpu_result, out_error<=0, go to RESP.
  - Otherwise the counter increments. At the edge where the counter equals TIMEOUT-1 with fpu_ready=0: out_result<=0, out_error<=1, go to RESP.
  - fpu_ready wins if it coincides with the timeout edge.
- RESP:
  - out_valid=1; out_result/out_tag/out_error held stable while out_ready=0.
  - On out_valid&&out_ready: go to IDLE, out_valid drops the next cycle.
  - A new request cannot be accepted in the same cycle (in_ready=0 in RESP). This guarantees at least one FPU_ADD flush cycle between back-to-back operations.
- Latency from acceptance edge to out_valid:
  - ADD/SUB: 1 edge, since FPU ready is immediate.
  - MUL: FPU stage count, about 6 edges.
  - SQRT: about 2+ITER edges, about 24 for WIDTH=32/FBITS=10.
- Throughput: at most one operation per latency+2 cycles.
- Widths: no arithmetic on data; the counter is clog2(TIMEOUT) bits and saturation is never reached.
- Illegal in_op: not possible, since all 4 codes are legal.

Decomposition:
- Shared defines (existing Defines.vh): FPU_ADD/SUB/MUL/SQRT codes.
- Add to the same header: controller state encodings IDLE/ISSUE/RESP and the default TIMEOUT.
- No sub-module is needed. The watchdog counter is inline and stays within the single module.

Test Plan:
- Stimulus: ADD in_a=0x600 (1.5), in_b=0x800 (2.0), tag=3. Required: one FPU-ready edge later out_valid=1, out_result=0xE00, out_tag=3, out_error=0.
- Stimulus: MUL 0x600*0x800. Required: fpu_operation=MUL held and operands stable until fpu_ready; out_result=0xC00 (3.0); latency 5..7 edges.
- Stimulus: SQRT in_a=0x1000 (4.0), back-to-back after a MUL with out_ready=1 always. Required: at least one cycle of fpu_operation=FPU_ADD between the ops; out_result=0x800 (2.0).
- Stimulus: backpressure, with out_ready=0 for 10 cycles after SUB 0x800-0x600. Required: out_valid stays 1, out_result=0x200 stable, in_ready=0; completes on the first out_ready=1.
- Stimulus: FPU stub with fpu_ready tied 0, TIMEOUT=8. Required: exactly 8 ISSUE cycles, then out_valid=1, out_error=1, out_result=0, tag preserved.
- Stimulus: reset pulled to 0 during SQRT ISSUE. Required: immediately fpu_operation=FPU_ADD, busy=0, in_ready=1, no response after release; a new ADD completes normally.
